// File: rtl/imm_extend_if.sv
// Handshake bundle for the immediate-extension stage: a valid/ready request side
// and a valid/ready result side.
interface imm_extend_if #(
  parameter int unsigned IN_WIDTH  = 6,
  parameter int unsigned OUT_WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  in_data;
  logic [1:0]           in_mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_ovf;

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// Registered immediate extension (zero / sign / upper / sign-and-scale) behind a
// 2-entry skid buffer, so a stalled consumer can backpressure decode losslessly.
module imm_extend_pipe #(
  parameter int unsigned IN_WIDTH  = 6,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned SHIFT     = 1
) (
  input  logic         clk,
  input  logic         rst,
  imm_extend_if.slave  bus
);

  if (IN_WIDTH < 1 || IN_WIDTH > OUT_WIDTH) begin : gen_bad_in_width
    $error("imm_extend_pipe: IN_WIDTH must be in 1..OUT_WIDTH");
  end
  if (SHIFT >= OUT_WIDTH) begin : gen_bad_shift
    $error("imm_extend_pipe: SHIFT must be below OUT_WIDTH");
  end

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e               state_q;
  logic                 in_ready_q;
  logic [OUT_WIDTH-1:0] head_data_q, skid_data_q;
  logic                 head_ovf_q, skid_ovf_q;

  logic [OUT_WIDTH-1:0] zext, sext, ovf_bits, ext_data;
  logic                 ext_ovf;
  logic                 accept, drain;

  // Fill shifts by IN_WIDTH rather than slicing, so IN_WIDTH == OUT_WIDTH needs no
  // zero-width concatenation.
  always_comb begin
    zext     = OUT_WIDTH'(bus.in_data);
    sext     = zext | ({OUT_WIDTH{bus.in_data[IN_WIDTH-1]}} << IN_WIDTH);
    // Bits that the scale pushes out must all match the sign for the value to survive.
    ovf_bits = (sext ^ {OUT_WIDTH{sext[OUT_WIDTH-1]}}) & ~({OUT_WIDTH{1'b1}} >> (SHIFT + 1));
    ext_data = zext;
    ext_ovf  = 1'b0;
    case (bus.in_mode)
      2'd0: ext_data = zext;
      2'd1: ext_data = sext;
      2'd2: ext_data = zext << (OUT_WIDTH - IN_WIDTH);
      default: begin
        ext_data = sext << SHIFT;
        ext_ovf  = |ovf_bits;
      end
    endcase
  end

  assign bus.in_ready  = in_ready_q & ~rst;
  assign bus.out_valid = (state_q != StEmpty);
  assign bus.out_data  = head_data_q;
  assign bus.out_ovf   = head_ovf_q;

  assign accept = bus.in_valid & bus.in_ready;
  assign drain  = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StEmpty;
      in_ready_q  <= 1'b1;
      head_data_q <= '0;
      head_ovf_q  <= 1'b0;
      skid_data_q <= '0;
      skid_ovf_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            head_data_q <= ext_data;
            head_ovf_q  <= ext_ovf;
            state_q     <= StOne;
          end
        end
        StOne: begin
          if (accept && !drain) begin
            skid_data_q <= ext_data;
            skid_ovf_q  <= ext_ovf;
            state_q     <= StTwo;
            in_ready_q  <= 1'b0;
          end else if (accept && drain) begin
            head_data_q <= ext_data;
            head_ovf_q  <= ext_ovf;
          end else if (drain) begin
            state_q <= StEmpty;
          end
        end
        StTwo: begin
          if (drain) begin
            head_data_q <= skid_data_q;
            head_ovf_q  <= skid_ovf_q;
            state_q     <= StOne;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q    <= StEmpty;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed + random bench for imm_extend_pipe: a 6-bit and a 16-bit instance, both
// scoreboarded against an arithmetic reference model.
module tb_imm_extend_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imm_extend_if #(.IN_WIDTH(6),  .OUT_WIDTH(16)) a_if ();
  imm_extend_if #(.IN_WIDTH(16), .OUT_WIDTH(16)) b_if ();

  imm_extend_pipe #(.IN_WIDTH(6), .OUT_WIDTH(16), .SHIFT(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  imm_extend_pipe #(.IN_WIDTH(16), .OUT_WIDTH(16), .SHIFT(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  int tests = 0;
  int fails = 0;
  logic [16:0] qa[$];
  logic [16:0] qb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: value arithmetic, SHIFT fixed at 1; result is {ovf, data}.
  function automatic logic [16:0] model(input int inw, input logic [15:0] d,
                                        input logic [1:0] m);
    logic [15:0] mask;
    logic [15:0] dm;
    int          v;
    longint      p;
    mask = (inw == 16) ? 16'hFFFF : 16'((32'd1 << inw) - 1);
    dm   = d & mask;
    v    = int'(dm);
    if (dm[inw-1]) v = v - (1 << inw);
    case (m)
      2'd0:    return {1'b0, dm};
      2'd1:    return {1'b0, 16'(v)};
      2'd2:    return {1'b0, 16'(dm << (16 - inw))};
      default: begin
        p = longint'(v) * 2;
        return {(p > 32767 || p < -32768), 16'(p)};
      end
    endcase
  endfunction

  // Score the current cycle's transfers, then advance to #1 after the next edge.
  task automatic tick();
    logic [16:0] e;
    if (a_if.out_valid && a_if.out_ready) begin
      if (qa.size() == 0) chk("a_spurious_out", {31'd0, a_if.out_valid}, 32'd0);
      else begin
        e = qa.pop_front();
        chk("a_sb_data", {16'd0, a_if.out_data}, {16'd0, e[15:0]});
        chk("a_sb_ovf", {31'd0, a_if.out_ovf}, {31'd0, e[16]});
      end
    end
    if (a_if.in_valid && a_if.in_ready)
      qa.push_back(model(6, {10'd0, a_if.in_data}, a_if.in_mode));
    if (b_if.out_valid && b_if.out_ready) begin
      if (qb.size() == 0) chk("b_spurious_out", {31'd0, b_if.out_valid}, 32'd0);
      else begin
        e = qb.pop_front();
        chk("b_sb_data", {16'd0, b_if.out_data}, {16'd0, e[15:0]});
        chk("b_sb_ovf", {31'd0, b_if.out_ovf}, {31'd0, e[16]});
      end
    end
    if (b_if.in_valid && b_if.in_ready)
      qb.push_back(model(16, b_if.in_data, b_if.in_mode));
    @(posedge clk);
    #1;
  endtask

  logic [15:0] t1_exp [4];
  logic [15:0] prev_data;
  logic        prev_ovf;
  logic        prev_stall;

  initial begin
    t1_exp = '{16'h002D, 16'hFFED, 16'hB400, 16'hFFDA};
    a_if.in_valid = 1'b1; a_if.in_data = 6'h3F; a_if.in_mode = 2'd1; a_if.out_ready = 1'b1;
    b_if.in_valid = 1'b0; b_if.in_data = '0;    b_if.in_mode = 2'd0; b_if.out_ready = 1'b1;

    // Reset state; inputs offered during reset must be discarded.
    @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, a_if.in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, a_if.out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, a_if.out_data}, 32'd0);
    chk("rst_out_ovf", {31'd0, a_if.out_ovf}, 32'd0);
    a_if.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("release_in_ready", {31'd0, a_if.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("release_no_ghost", {31'd0, a_if.out_valid}, 32'd0);

    // Four modes back to back, one result per cycle.
    a_if.in_valid = 1'b1;
    a_if.in_data  = 6'h2D;
    for (int m = 0; m < 4; m++) begin
      a_if.in_mode = 2'(m);
      tick();
      chk("mode_valid", {31'd0, a_if.out_valid}, 32'd1);
      chk("mode_data", {16'd0, a_if.out_data}, {16'd0, t1_exp[m]});
      chk("mode_ovf", {31'd0, a_if.out_ovf}, 32'd0);
    end
    a_if.in_valid = 1'b0;
    tick();

    // Full-width instance: scale overflow and pass-through.
    b_if.in_valid = 1'b1;
    b_if.in_mode  = 2'd3; b_if.in_data = 16'h4000; tick();
    chk("w16_4000_data", {16'd0, b_if.out_data}, 32'h8000);
    chk("w16_4000_ovf", {31'd0, b_if.out_ovf}, 32'd1);
    b_if.in_data = 16'hC000; tick();
    chk("w16_C000_data", {16'd0, b_if.out_data}, 32'h8000);
    chk("w16_C000_ovf", {31'd0, b_if.out_ovf}, 32'd0);
    b_if.in_mode = 2'd0; b_if.in_data = 16'h1234; tick();
    chk("w16_pass", {16'd0, b_if.out_data}, 32'h1234);
    b_if.in_mode = 2'd2; b_if.in_data = 16'hBEEF; tick();
    chk("w16_upper", {16'd0, b_if.out_data}, 32'hBEEF);
    b_if.in_valid = 1'b0;
    tick();

    // Backpressure: A and B fill the buffer, C waits.
    a_if.out_ready = 1'b0;
    a_if.in_valid  = 1'b1;
    a_if.in_mode   = 2'd0;
    a_if.in_data = 6'd1; tick();
    chk("bp_after_a_ready", {31'd0, a_if.in_ready}, 32'd1);
    a_if.in_data = 6'd2; tick();
    chk("bp_full_ready", {31'd0, a_if.in_ready}, 32'd0);
    a_if.in_data = 6'd3; tick();
    chk("bp_hold_ready", {31'd0, a_if.in_ready}, 32'd0);
    chk("bp_hold_data", {16'd0, a_if.out_data}, 32'h0001);
    tick();
    chk("bp_hold_data2", {16'd0, a_if.out_data}, 32'h0001);
    a_if.out_ready = 1'b1;
    tick();
    chk("bp_drain_b", {16'd0, a_if.out_data}, 32'h0002);
    tick();
    chk("bp_drain_c", {16'd0, a_if.out_data}, 32'h0003);
    a_if.in_valid = 1'b0;
    tick();
    chk("bp_empty", {31'd0, a_if.out_valid}, 32'd0);

    // Streaming: accept and drain together keeps the buffer at one entry.
    a_if.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a_if.in_data = 6'(i + 10);
      tick();
      chk("stream_ready", {31'd0, a_if.in_ready}, 32'd1);
      chk("stream_data", {16'd0, a_if.out_data}, 32'(i + 10));
    end
    a_if.in_valid = 1'b0;
    tick();

    // Asynchronous reset mid-cycle with two entries held.
    a_if.out_ready = 1'b0;
    a_if.in_valid  = 1'b1;
    a_if.in_mode   = 2'd3;
    a_if.in_data = 6'h21; tick();
    a_if.in_data = 6'h12; tick();
    chk("two_full", {31'd0, a_if.in_ready}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, a_if.out_valid}, 32'd0);
    chk("arst_out_data", {16'd0, a_if.out_data}, 32'd0);
    chk("arst_out_ovf", {31'd0, a_if.out_ovf}, 32'd0);
    chk("arst_in_ready", {31'd0, a_if.in_ready}, 32'd0);
    qa.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_release_ready", {31'd0, a_if.in_ready}, 32'd1);
    a_if.out_ready = 1'b1;
    a_if.in_mode   = 2'd1;
    a_if.in_data   = 6'h15;
    tick();
    chk("arst_first_item", {16'd0, a_if.out_data}, 32'h0015);
    a_if.in_valid = 1'b0;
    tick();
    chk("arst_no_stale", {31'd0, a_if.out_valid}, 32'd0);

    // Random traffic; also check the head holds while stalled.
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_ovf   = 1'b0;
    for (int i = 0; i < 400; i++) begin
      a_if.in_valid  = 1'($urandom_range(0, 1));
      a_if.in_data   = 6'($urandom);
      a_if.in_mode   = 2'($urandom);
      a_if.out_ready = ($urandom_range(0, 3) != 0);
      if (prev_stall) begin
        chk("stall_data", {16'd0, a_if.out_data}, {16'd0, prev_data});
        chk("stall_ovf", {31'd0, a_if.out_ovf}, {31'd0, prev_ovf});
      end
      prev_stall = a_if.out_valid && !a_if.out_ready;
      prev_data  = a_if.out_data;
      prev_ovf   = a_if.out_ovf;
      tick();
    end
    a_if.in_valid  = 1'b0;
    a_if.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("rand_all_drained", 32'(qa.size()), 32'd0);
    chk("rand_out_idle", {31'd0, a_if.out_valid}, 32'd0);
    chk("b_all_drained", 32'(qb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
